// File: rtl/rtc_pkg.sv
// rtc_pkg: register map, command bit positions, FSM encoding and BCD increment helper for the 3-wire RTC responder
package rtc_pkg;
  localparam int ADDR_SEC = 0;
  localparam int ADDR_MIN = 1;
  localparam int ADDR_HOUR = 2;
  localparam int ADDR_DATE = 3;
  localparam int ADDR_MONTH = 4;
  localparam int ADDR_DAY = 5;
  localparam int ADDR_YEAR = 6;
  localparam int ADDR_CTRL = 7;
  localparam int CMD_VALID_BIT = 7;
  localparam int CMD_RAM_BIT = 6;
  localparam int WP_BIT = 7;
  localparam int CH_BIT = 7;
  typedef enum logic [2:0] {IDLE, CMD, WDATA, RDATA, DONE} state_t;
  function automatic logic [8:0] bcd_inc(input logic [7:0] val, input logic [7:0] max);
    return val >= max ? 9'h100 : val[3:0] == 4'd9 ? {1'b0, val[7:4] + 4'd1, 4'd0} : {1'b0, val + 8'd1};
  endfunction
endpackage

// File: rtl/rtc_pin_sync.sv
// rtc_pin_sync: multi-flop input synchronizer with one-flop rise/fall pulse detection
module rtc_pin_sync #(
  parameter int STAGES = 2
) (
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q,
  output logic rise,
  output logic fall
);
  logic [STAGES-1:0] sync;
  logic prev;
  always_ff @(posedge clk)
    if (rst) begin
      sync <= '0;
      prev <= 1'b0;
    end else begin
      sync <= {sync[STAGES-2:0], d};
      prev <= sync[STAGES-1];
    end
  assign q = sync[STAGES-1];
  assign rise = q & ~prev;
  assign fall = ~q & prev;
endmodule

// File: rtl/rtc_3wire_responder.sv
// rtc_3wire_responder: DS1302-style 3-wire RTC bus slave with 8x8 clock register file; define RTC_TICK_EN for the seconds prescaler
module rtc_3wire_responder
  import rtc_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int TICK_CYCLES = 50_000_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        rtc_rst,
  input  logic        rtc_sclk,
  input  logic        sio_in,
  output logic        sio_out,
  output logic        sio_oe,
  output logic [23:0] rtc_time
);
  state_t state, state_n;
  logic ce_s, ce_rise, ce_fall, sclk_s, sclk_rise, sclk_fall, sio_s, sio_rise, sio_fall;
  logic [2:0] bit_cnt, addr;
  logic [6:0] sh;
  logic [7:0] rx, out_sr;
  logic [7:0] regs [8];
  logic cmd_ok, last_rise, wr_en;
  logic unused_ok;
  rtc_pin_sync #(.STAGES(SYNC_STAGES)) u_ce (.clk(clk), .rst(rst), .d(rtc_rst), .q(ce_s), .rise(ce_rise), .fall(ce_fall));
  rtc_pin_sync #(.STAGES(SYNC_STAGES)) u_sclk (.clk(clk), .rst(rst), .d(rtc_sclk), .q(sclk_s), .rise(sclk_rise), .fall(sclk_fall));
  rtc_pin_sync #(.STAGES(SYNC_STAGES)) u_sio (.clk(clk), .rst(rst), .d(sio_in), .q(sio_s), .rise(sio_rise), .fall(sio_fall));
  assign unused_ok = ^{ce_fall, sclk_s, sio_rise, sio_fall};
  assign rx = {sio_s, sh};
  assign cmd_ok = rx[CMD_VALID_BIT] && !rx[CMD_RAM_BIT] && rx[5:4] == 2'b00;
  assign last_rise = sclk_rise && bit_cnt == 3'd7;
  assign wr_en = state == WDATA && ce_s && last_rise && (addr == 3'(ADDR_CTRL) || !regs[ADDR_CTRL][WP_BIT]);
  assign rtc_time = {regs[ADDR_HOUR], regs[ADDR_MIN], regs[ADDR_SEC]};
  always_ff @(posedge clk)
    state <= rst ? IDLE : state_n;
  always_comb begin
    state_n = state;
    if (state == IDLE) state_n = ce_rise ? CMD : IDLE;
    else if (!ce_s) state_n = IDLE;
    else if (state == CMD && last_rise) state_n = !cmd_ok ? DONE : rx[0] ? RDATA : WDATA;
    else if (state == WDATA && last_rise) state_n = DONE;
    else if (state == RDATA && sclk_fall && sio_oe && bit_cnt == 3'd0) state_n = DONE;
  end
  always_ff @(posedge clk)
    if (rst) begin
      bit_cnt <= '0;
      addr <= '0;
      sh <= '0;
      out_sr <= '0;
      sio_out <= 1'b0;
      sio_oe <= 1'b0;
    end else if (state == IDLE || state_n == IDLE) begin
      bit_cnt <= '0;
      sio_oe <= 1'b0;
    end else begin
      if (sclk_rise && (state == CMD || state == WDATA)) begin
        sh <= rx[7:1];
        bit_cnt <= bit_cnt + 3'd1;
      end
      if (state == CMD && last_rise) begin
        addr <= rx[3:1];
        out_sr <= regs[rx[3:1]];
      end
      if (state == RDATA && sclk_fall) begin
        sio_oe <= !(sio_oe && bit_cnt == 3'd0);
        sio_out <= out_sr[0];
        out_sr <= {1'b0, out_sr[7:1]};
        bit_cnt <= bit_cnt + 3'd1;
      end
    end
`ifdef RTC_TICK_EN
  localparam int PRE_W = TICK_CYCLES > 1 ? $clog2(TICK_CYCLES) : 1;
  logic [PRE_W-1:0] pre;
  logic wrap, sec_wr, tick, unused_carry;
  logic [8:0] sec_n, min_n, hour_n;
  assign wrap = pre == PRE_W'(TICK_CYCLES - 1);
  assign sec_wr = wr_en && addr == 3'(ADDR_SEC);
  assign tick = wrap && !regs[ADDR_SEC][CH_BIT] && !sec_wr;
  assign sec_n = bcd_inc(regs[ADDR_SEC], 8'h59);
  assign min_n = bcd_inc(regs[ADDR_MIN], 8'h59);
  assign hour_n = bcd_inc({2'b00, regs[ADDR_HOUR][5:0]}, 8'h23);
  assign unused_carry = hour_n[8];
  always_ff @(posedge clk)
    pre <= rst || sec_wr || wrap ? '0 : pre + PRE_W'(1);
`else
  localparam int unused_tick_cycles = TICK_CYCLES;
`endif
  always_ff @(posedge clk)
    if (rst) begin
      for (int i = 0; i < 8; i++)
        regs[i] <= (i == ADDR_DATE || i == ADDR_MONTH || i == ADDR_DAY) ? 8'h01 : 8'h00;
    end else begin
`ifdef RTC_TICK_EN
      if (tick) begin
        regs[ADDR_SEC] <= sec_n[7:0];
        if (sec_n[8]) regs[ADDR_MIN] <= min_n[7:0];
        if (sec_n[8] && min_n[8]) regs[ADDR_HOUR] <= hour_n[7:0];
      end
`endif
      if (wr_en) regs[addr] <= rx;
    end
endmodule

// File: tb/tb_rtc_3wire_responder.sv
// tb_rtc_3wire_responder: directed scoreboard bench for the 3-wire RTC responder (RTC_TICK_EN selects the tick test)
module tb_rtc_3wire_responder;
  logic clk = 1'b0, rst = 1'b1, rtc_rst = 1'b0, rtc_sclk = 1'b0, sio_in = 1'b0;
  logic sio_out, sio_oe;
  logic [23:0] rtc_time;
  int n_vec = 0, n_err = 0, oe_hi = 0, base;
  logic [7:0] got;
  logic [7:0] exp_q [$];
  logic [7:0] bad [6] = '{8'h40, 8'hC1, 8'hBF, 8'h00, 8'h90, 8'hC0};
  rtc_3wire_responder #(.SYNC_STAGES(2), .TICK_CYCLES(4)) dut (
    .clk(clk), .rst(rst), .rtc_rst(rtc_rst), .rtc_sclk(rtc_sclk), .sio_in(sio_in),
    .sio_out(sio_out), .sio_oe(sio_oe), .rtc_time(rtc_time)
  );
  always #5 clk = ~clk;
  always @(negedge clk) if (sio_oe) oe_hi++;
  task automatic clk_wait(input int n);
    repeat (n) @(negedge clk);
  endtask
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask
  task automatic ce_on();
    rtc_rst = 1'b1;
    clk_wait(6);
  endtask
  task automatic ce_off();
    rtc_rst = 1'b0;
    sio_in = 1'b0;
    clk_wait(6);
  endtask
  task automatic send_bits(input logic [7:0] b, input int n);
    for (int i = 0; i < n; i++) begin
      sio_in = b[i];
      clk_wait(3);
      rtc_sclk = 1'b1;
      clk_wait(6);
      rtc_sclk = 1'b0;
      clk_wait(3);
    end
  endtask
  task automatic read_bits(input int n, output logic [7:0] b);
    b = '0;
    for (int i = 0; i < n; i++) begin
      clk_wait(3);
      check($sformatf("oe_bit%0d", i), sio_oe, 1);
      b[i] = sio_out;
      rtc_sclk = 1'b1;
      clk_wait(6);
      rtc_sclk = 1'b0;
      clk_wait(3);
    end
  endtask
  task automatic write_txn(input logic [7:0] cmd, input logic [7:0] data);
    ce_on();
    send_bits(cmd, 8);
    send_bits(data, 8);
    ce_off();
  endtask
  task automatic read_txn(input logic [7:0] cmd, input logic [7:0] exp);
    logic [7:0] b;
    exp_q.push_back(exp);
    ce_on();
    send_bits(cmd, 8);
    read_bits(8, b);
    clk_wait(6);
    check($sformatf("oe_off_%02h", cmd), sio_oe, 0);
    ce_off();
    check($sformatf("rdata_%02h", cmd), b, exp_q.pop_front());
  endtask
  initial begin
    clk_wait(5);
    rst = 1'b0;
    clk_wait(2);
    check("rst_oe", sio_oe, 0);
    check("rst_out", sio_out, 0);
    check("rst_time", rtc_time, 24'h000000);
`ifdef RTC_TICK_EN
    write_txn(8'h80, 8'h80);
    write_txn(8'h84, 8'h23);
    write_txn(8'h82, 8'h59);
    check("t5_hold", rtc_time, 24'h235980);
    ce_on();
    send_bits(8'h80, 8);
    send_bits(8'h59, 7);
    sio_in = 1'b0;
    clk_wait(3);
    rtc_sclk = 1'b1;
    for (int i = 0; i < 12 && rtc_time[7:0] !== 8'h59; i++) clk_wait(1);
    check("t5_load", rtc_time[7:0], 8'h59);
    clk_wait(3);
    check("t5_pre", rtc_time, 24'h235959);
    clk_wait(1);
    check("t5_roll", rtc_time, 24'h000000);
    clk_wait(6);
    rtc_sclk = 1'b0;
    clk_wait(3);
    ce_off();
    write_txn(8'h80, 8'h80);
    clk_wait(40);
    check("t5_ch", rtc_time, 24'h000080);
`else
    read_txn(8'h87, 8'h01);
    read_txn(8'h8B, 8'h01);
    read_txn(8'h8F, 8'h00);
    write_txn(8'h80, 8'h45);
    check("t1_time", rtc_time, 24'h000045);
    read_txn(8'h81, 8'h45);
    write_txn(8'h8E, 8'h80);
    write_txn(8'h84, 8'h12);
    check("t2_wp_on", rtc_time, 24'h000045);
    read_txn(8'h8F, 8'h80);
    write_txn(8'h8E, 8'h00);
    write_txn(8'h84, 8'h12);
    check("t2_wp_off", rtc_time, 24'h120045);
    ce_on();
    send_bits(8'h82, 8);
    send_bits(8'hFF, 5);
    rtc_rst = 1'b0;
    clk_wait(4);
    check("t3_wr_abort_oe", sio_oe, 0);
    check("t3_wr_abort_time", rtc_time, 24'h120045);
    ce_off();
    ce_on();
    send_bits(8'h81, 8);
    read_bits(3, got);
    check("t3_rd_bits", got[2:0], 3'b101);
    rtc_rst = 1'b0;
    clk_wait(4);
    check("t3_rd_abort_oe", sio_oe, 0);
    ce_off();
    read_txn(8'h83, 8'h00);
    for (int i = 0; i < 6; i++) begin
      base = oe_hi;
      ce_on();
      send_bits(bad[i], 8);
      send_bits(8'h5A, 8);
      ce_off();
      check($sformatf("t4_oe_%02h", bad[i]), oe_hi - base, 0);
      check($sformatf("t4_time_%02h", bad[i]), rtc_time, 24'h120045);
    end
    read_txn(8'h81, 8'h45);
    ce_on();
    send_bits(8'h85, 8);
    read_bits(3, got);
    check("t6_bits", got[2:0], 3'b010);
    rst = 1'b1;
    clk_wait(1);
    check("t6_oe", sio_oe, 0);
    check("t6_time", rtc_time, 24'h000000);
    rtc_rst = 1'b0;
    clk_wait(3);
    rst = 1'b0;
    clk_wait(6);
    read_txn(8'h87, 8'h01);
    read_txn(8'h8F, 8'h00);
    read_txn(8'h81, 8'h00);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
